// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and baud timing helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int CLKS_PER_BIT_DEFAULT = 104;

  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, with a selectable reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_feeder.sv
// 8N1 UART receiver that pushes each good byte into the console FIFO write port.
// state | meaning
// IDLE  | line idle, waiting for a falling edge on rx_s
// START | timing to mid start bit, rejecting glitches
// DATA  | sampling WIDTH data bits, LSB first, once per bit period
// STOP  | timing to mid stop bit, then push / frame error / overrun
module uart_rx_fifo_feeder
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_rx,
  input  logic             i_set_ack,
  output logic             o_set,
  output logic [WIDTH-1:0] o_data,
  output logic             o_frame_err,
  output logic             o_overrun,
  output logic             o_busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(WIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(half_bit(CLKS_PER_BIT) - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WIDTH - 1);

  logic             rx_s;
  rx_state_t        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             baud_tc;
  logic             push_req;
  logic             frame_err_d;
  logic             overrun_d;
  logic             ack_low_q;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .d       (i_rx),
    .q       (rx_s)
  );

  assign baud_tc = (baud_q == '0);
  assign o_busy  = (state_q != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push_req    = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!rx_s) begin
          state_d = START;
          baud_d  = BAUD_HALF;
        end
      end
      START: begin
        if (baud_tc) begin
          if (!rx_s) begin
            state_d = DATA;
            baud_d  = BAUD_FULL;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      DATA: begin
        if (baud_tc) begin
          shift_d = {rx_s, shift_q[WIDTH-1:1]};
          baud_d  = BAUD_FULL;
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      STOP: begin
        // Returning to IDLE at mid stop bit leaves half a bit to catch a back-to-back start.
        if (baud_tc) begin
          state_d = IDLE;
          if (!rx_s) begin
            frame_err_d = 1'b1;
          end else if (o_set) begin
            overrun_d = 1'b1;
          end else begin
            push_req = 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!i_en) begin
      state_d     = IDLE;
      baud_d      = '0;
      bit_d       = '0;
      push_req    = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  // An ack already high when o_set rises is stale; only an ack after a seen-low counts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_set       <= 1'b0;
      o_data      <= '0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      ack_low_q   <= 1'b0;
    end else begin
      o_frame_err <= frame_err_d;
      o_overrun   <= overrun_d;
      if (push_req) begin
        o_set     <= 1'b1;
        o_data    <= shift_q;
        ack_low_q <= 1'b0;
      end else if (o_set) begin
        if (!i_set_ack) begin
          ack_low_q <= 1'b1;
        end else if (ack_low_q) begin
          o_set     <= 1'b0;
          ack_low_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/uart_rx_fifo_feeder.md
Name: uart_rx_fifo_feeder

Overview:
Serial byte receiver sitting directly upstream of the byte FIFO on the console/input path of the Forth CPU. It deserialises 8N1 UART frames from the asynchronous i_rx pin and pushes each good byte into the FIFO's write port. Each push uses the FIFO's pulse handshake: request on i_set, acknowledge on o_set. Framing errors and overruns are flagged. The offending byte is dropped and the push path is never corrupted.

Parameters:
WIDTH, 8, data bits per frame; equals FIFO WIDTH.
CLKS_PER_BIT, 104, i_clk cycles per UART bit period; must be >= 4 and even.

Ports:
i_clk  input  1  system clock.
i_rst_n  input  1  asynchronous, active-low reset.
i_en  input  1  receiver enable; low holds the FSM in IDLE. A pending push still completes.
i_rx  input  1  raw asynchronous serial line; idles high.
i_set_ack  input  1  FIFO o_set acknowledge.
o_set  output  1  push request; drives the FIFO i_set.
o_data  output  WIDTH  byte being pushed; drives the FIFO i_data.
o_frame_err  output  1  one-cycle pulse; stop bit sampled low.
o_overrun  output  1  one-cycle pulse; a byte completed while a push was still pending.
o_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
Reset (async assert, sync release):
- FSM goes to IDLE.
- Outputs: o_set=0, o_data=0, o_frame_err=0, o_overrun=0, o_busy=0.
- Synchroniser flops are forced to 1 (line idle).
- Bit counter and baud counter go to 0.

Synchroniser:
- i_rx passes through 2 flops to give rx_s.
- Everything below sees rx_s only, so there are 2 cycles of input latency.

FSM states: IDLE, START, DATA, STOP.
- IDLE: if i_en && rx_s==0, go to START and load the baud counter. Otherwise stay in IDLE.
- START: count CLKS_PER_BIT/2 cycles (mid start bit), then recheck rx_s.
  - rx_s==0: go to DATA, bit counter=0.
  - rx_s==1: glitch; return to IDLE with no flags.
- DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first.
  - After WIDTH samples, go to STOP.
- STOP: after CLKS_PER_BIT cycles (mid stop bit), sample rx_s and go to IDLE in all cases.
  - rx_s==1 and o_set==0: o_data <= shifted byte and o_set <= 1, both on that edge.
  - rx_s==1 and o_set==1: o_overrun pulses for 1 cycle; byte discarded; o_data untouched.
  - rx_s==0: o_frame_err pulses for 1 cycle; byte discarded; o_set untouched.
- IDLE is re-entered at mid stop bit, so a back-to-back start bit is caught.

Push handshake (matches FIFO semantics: a write happens on the edge where i_set && !o_set):
- o_set stays high until an edge samples i_set_ack==1. At that edge o_set <= 0.
- Result: exactly one FIFO write per byte. o_set is never high for more than 1 cycle after the ack.
- o_data is stable for the whole time o_set is high.
- If i_set_ack is already 1 when o_set rises (stale ack), o_set must still stay high until a fresh ack edge.
  - Implementation: a "seen ack low" flag, set on any edge where o_set && !i_set_ack.
  - o_set drops only on an edge where o_set && flag && i_set_ack.

Latency:
- o_set rises 2 + CLKS_PER_BIT/2 + (WIDTH+1)*CLKS_PER_BIT cycles after the raw falling edge of the start bit, with a tolerance of +/-1 cycle.

i_en:
- Deassert mid-frame: FSM returns to IDLE on the next edge and the partial byte is discarded silently.
- o_set and ack handling are unaffected by i_en.

Reset mid-frame or mid-push: all state cleared immediately; no write is issued after reset release.

Counters:
- Baud counter width: $clog2(CLKS_PER_BIT).
- Bit counter width: $clog2(WIDTH+1).
- Neither counter wraps outside its state.

Decomposition:
- Package uart_pkg holds: the FSM state encoding (2-bit enum/localparams IDLE/START/DATA/STOP), the default CLKS_PER_BIT, and the HALF_BIT = CLKS_PER_BIT/2 constant function.
- One sub-module: sync_2ff, a 1-bit, 2-flop synchroniser with parameterised reset value (1 here) and the same async active-low reset.
- Everything else stays in uart_rx_fifo_feeder.

Test Plan:
All scenarios use CLKS_PER_BIT=8 and WIDTH=8, with a behavioural FIFO acknowledge model (ack = registered i_set && !ack) unless stated otherwise.
1. Send 0xA5 framed correctly -> o_set rises at 2+4+72 cycles (+/-1), o_data=0xA5; exactly one ack; o_set low 1 cycle after the ack; o_frame_err=o_overrun=0.
2. Send 0x3C with the stop bit driven 0 -> o_frame_err pulses 1 cycle; o_set stays 0; o_data keeps its previous value; next frame 0x11 is received normally.
3. Drive i_rx low for 2 cycles in IDLE, then high -> returns to IDLE after the half bit; no o_set, no flags; o_busy high for about 4 cycles then low.
4. Hold i_set_ack=0 and send 0x01 then 0x02 back-to-back -> o_set high with o_data=0x01; o_overrun pulses at the second stop bit; o_data still 0x01; releasing the ack yields a single write of 0x01.
5. Send 0x00, 0xFF, 0x55 back-to-back with the ack model -> exactly three writes, values in order; no flags.
6. Assert i_rst_n=0 mid-DATA of 0x7E and, separately, while o_set=1 -> all outputs 0 asynchronously; no write after release; a following 0x42 is received correctly.
